// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   Parametrised pipelined add/subtract unit with AVR-style status flags and
//   a valid/ready handshake. Each of the STAGES stages resolves WIDTH/STAGES
//   bits of the carry chain; unprocessed operand slices and finished result
//   slices travel with the beat through the stage registers.
//
// Ports
//   cp2        in   system clock, rising edge
//   ireset     in   asynchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  unit accepts a beat this cycle
//   a, b       in   operands (WIDTH)
//   ci         in   carry-in (add) / borrow-in (sub)
//   sub        in   0: s = a + b + ci, 1: s = a - b - ci
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts the result
//   s          out  sum / difference (WIDTH)
//   co         out  carry-out (add) / borrow-out (sub)
//   z, n, v    out  zero, negative, two's-complement overflow
//   h          out  carry / borrow out of bit 3
// ---------------------------------------------------------------------------
module pipelined_adder #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 2
) (
   input  logic             cp2,
   input  logic             ireset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             z,
   output logic             n,
   output logic             v,
   output logic             h
);

   localparam int unsigned SEG    = WIDTH / STAGES;
   localparam int unsigned LAST   = STAGES - 1;
   // Stage whose slice contains bit 3 (the half-carry position).
   localparam int unsigned HSTAGE = 3 / SEG;

   if (WIDTH < 8 || STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipelined_adder: unsupported WIDTH/STAGES combination");
   end

   // Stage registers
   logic             vld_q [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] bp_q  [STAGES];
   logic [WIDTH-1:0] s_q   [STAGES];
   logic             c_q   [STAGES];
   logic             sub_q [STAGES];
   logic             h_q   [STAGES];

   logic             vld_d [STAGES];
   logic [WIDTH-1:0] a_d   [STAGES];
   logic [WIDTH-1:0] bp_d  [STAGES];
   logic [WIDTH-1:0] s_d   [STAGES];
   logic             c_d   [STAGES];
   logic             sub_d [STAGES];
   logic             h_d   [STAGES];

   // Stage inputs: ports for stage 0, previous stage register otherwise
   logic             src_vld [STAGES];
   logic [WIDTH-1:0] src_a   [STAGES];
   logic [WIDTH-1:0] src_bp  [STAGES];
   logic [WIDTH-1:0] src_s   [STAGES];
   logic             src_c   [STAGES];
   logic             src_sub [STAGES];
   logic             src_h   [STAGES];

   // Final-result flags, registered alongside the last stage
   logic co_q, z_q, n_q, v_q;
   logic co_d, z_d, n_d, v_d;

   logic [SEG:0] seg_sum;
   logic         adv;

   assign adv      = !vld_q[LAST] || out_ready;
   assign in_ready = ireset && adv;

   always_comb begin
      src_vld[0] = in_valid;
      src_a[0]   = a;
      src_bp[0]  = sub ? ~b : b;
      src_c[0]   = ci ^ sub;
      src_sub[0] = sub;
      src_s[0]   = '0;
      src_h[0]   = 1'b0;
      for (int unsigned k = 1; k < STAGES; k++) begin
         src_vld[k] = vld_q[k-1];
         src_a[k]   = a_q[k-1];
         src_bp[k]  = bp_q[k-1];
         src_c[k]   = c_q[k-1];
         src_sub[k] = sub_q[k-1];
         src_s[k]   = s_q[k-1];
         src_h[k]   = h_q[k-1];
      end
   end

   always_comb begin
      seg_sum = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         vld_d[k] = src_vld[k];
         a_d[k]   = src_a[k];
         bp_d[k]  = src_bp[k];
         sub_d[k] = src_sub[k];
         h_d[k]   = src_h[k];
         s_d[k]   = src_s[k];
         seg_sum  = {1'b0, src_a[k][k*SEG +: SEG]}
                  + {1'b0, src_bp[k][k*SEG +: SEG]}
                  + {{SEG{1'b0}}, src_c[k]};
         s_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
         c_d[k]   = seg_sum[SEG];
         if (k == HSTAGE) begin
            // Carry out of bit 3 rebuilt from its operands and sum bit:
            // c4 = a3&b3 | (a3^b3)&~s3, then inverted to a borrow for sub.
            h_d[k] = ((src_a[k][3] & src_bp[k][3])
                     | ((src_a[k][3] ^ src_bp[k][3]) & ~s_d[k][3])) ^ src_sub[k];
         end
      end
      co_d = c_d[LAST] ^ sub_d[LAST];
      z_d  = (s_d[LAST] == '0);
      n_d  = s_d[LAST][WIDTH-1];
      v_d  = (a_d[LAST][WIDTH-1] == bp_d[LAST][WIDTH-1])
          && (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
   end

   always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            vld_q[k] <= 1'b0;
            a_q[k]   <= '0;
            bp_q[k]  <= '0;
            s_q[k]   <= '0;
            c_q[k]   <= 1'b0;
            sub_q[k] <= 1'b0;
            h_q[k]   <= 1'b0;
         end
         co_q <= 1'b0;
         z_q  <= 1'b0;
         n_q  <= 1'b0;
         v_q  <= 1'b0;
      end else if (adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            vld_q[k] <= vld_d[k];
            a_q[k]   <= a_d[k];
            bp_q[k]  <= bp_d[k];
            s_q[k]   <= s_d[k];
            c_q[k]   <= c_d[k];
            sub_q[k] <= sub_d[k];
            h_q[k]   <= h_d[k];
         end
         co_q <= co_d;
         z_q  <= z_d;
         n_q  <= n_d;
         v_q  <= v_d;
      end
   end

   assign out_valid = vld_q[LAST];
   assign s         = s_q[LAST];
   assign co        = co_q;
   assign z         = z_q;
   assign n         = n_q;
   assign v         = v_q;
   assign h         = h_q[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
//   Bench for pipelined_adder: a 16-bit/2-stage instance driven by a vector
//   table and hand-written handshake/reset sequences, and a 32-bit/4-stage
//   instance driven by random beats with random backpressure against an
//   arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

   localparam int unsigned NBEATS = 10000;

   typedef struct {
      longint unsigned s;
      bit co, z, n, v, h;
   } res_t;

   typedef struct {
      logic [15:0] a, b;
      logic        ci, sub;
      logic [15:0] s;
      logic        co, z, n, v, h;
   } vec_t;

   logic cp2 = 1'b0;
   logic ireset;
   always #5 cp2 = ~cp2;

   // 16-bit / 2-stage instance
   logic        iv16, ir16, ci16, sub16, ov16, or16, co16, z16, n16, v16, h16;
   logic [15:0] a16, b16, s16;
   // 32-bit / 4-stage instance
   logic        iv32, ir32, ci32, sub32, ov32, or32, co32, z32, n32, v32, h32;
   logic [31:0] a32, b32, s32;

   pipelined_adder #(.WIDTH(16), .STAGES(2)) dut16 (
      .cp2(cp2), .ireset(ireset), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .ci(ci16), .sub(sub16),
      .out_valid(ov16), .out_ready(or16), .s(s16),
      .co(co16), .z(z16), .n(n16), .v(v16), .h(h16)
   );

   pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (
      .cp2(cp2), .ireset(ireset), .in_valid(iv32), .in_ready(ir32),
      .a(a32), .b(b32), .ci(ci32), .sub(sub32),
      .out_valid(ov32), .out_ready(or32), .s(s32),
      .co(co32), .z(z32), .n(n32), .v(v32), .h(h32)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operands
   function automatic res_t model(int unsigned w, longint unsigned a, longint unsigned b,
                                  bit ci, bit sub);
      res_t r;
      longint unsigned mask = (64'd1 << w) - 64'd1;
      longint lim = longint'(64'd1 << (w - 1));
      longint sa, sb, sr;
      longint unsigned full;
      sa = a[w-1] ? longint'(a) - longint'(mask) - 1 : longint'(a);
      sb = b[w-1] ? longint'(b) - longint'(mask) - 1 : longint'(b);
      if (!sub) begin
         full = a + b + 64'(ci);
         r.co = full > mask;
         r.h  = ((a & 64'hF) + (b & 64'hF) + 64'(ci)) > 64'hF;
         sr   = sa + sb + longint'(ci);
      end else begin
         full = a - b - 64'(ci);
         r.co = a < b + 64'(ci);
         r.h  = (a & 64'hF) < (b & 64'hF) + 64'(ci);
         sr   = sa - sb - longint'(ci);
      end
      r.s = full & mask;
      r.z = (r.s == 0);
      r.n = r.s[w-1];
      r.v = (sr >= lim) || (sr < -lim);
      return r;
   endfunction

   vec_t        vt [10];
   int unsigned lat, sent, seen, acc, cyc;
   logic [15:0] held;
   logic [15:0] got16 [$];
   res_t        expq [$];
   res_t        e;

   initial begin
      vt[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      vt[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[3] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vt[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[6] = '{16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[7] = '{16'h0008, 16'h0008, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[9] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      ireset = 1'b0;
      iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
      iv32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; sub32 = 1'b0; or32 = 1'b1;

      // Reset state
      repeat (3) @(posedge cp2);
      #1;
      check("reset_state16", {ov16, s16, co16, z16, n16, v16, h16, ir16}, '0);
      check("reset_state32", {ov32, s32, co32, z32, n32, v32, h32, ir32}, '0);
      #2 ireset = 1'b1;
      @(posedge cp2); #1;
      check("ready_after_release16", ir16, 1'b1);
      check("ready_after_release32", ir32, 1'b1);

      // Vector table, one beat at a time, unstalled
      for (int i = 0; i < 10; i++) begin
         iv16 = 1'b1; a16 = vt[i].a; b16 = vt[i].b; ci16 = vt[i].ci; sub16 = vt[i].sub;
         @(posedge cp2); #1;
         iv16 = 1'b0;
         lat = 1;
         while (!ov16 && lat < 20) begin
            @(posedge cp2); #1;
            lat++;
         end
         check("vec_latency", lat, 2);
         check("vec_s", s16, vt[i].s);
         check("vec_co", co16, vt[i].co);
         check("vec_z", z16, vt[i].z);
         check("vec_n", n16, vt[i].n);
         check("vec_v", v16, vt[i].v);
         check("vec_h", h16, vt[i].h);
         @(posedge cp2); #1;
         check("vec_no_dup", ov16, 1'b0);
      end

      // Backpressure: five beats k+k, consumer stalls in cycles 3..5
      sent = 0;
      for (int c = 0; c < 30; c++) begin
         or16 = !(c >= 3 && c <= 5);
         if (sent < 5) begin
            iv16 = 1'b1; a16 = 16'(sent + 1); b16 = 16'(sent + 1); ci16 = 1'b0; sub16 = 1'b0;
         end else begin
            iv16 = 1'b0;
         end
         #1;
         if (c >= 3 && c <= 5) begin
            check("stall_in_ready", ir16, 1'b0);
            check("stall_out_valid", ov16, 1'b1);
            if (c == 3) held = s16;
            else check("stall_s_hold", s16, held);
         end
         if (ov16 && or16) got16.push_back(s16);
         if (iv16 && ir16) sent++;
         @(posedge cp2); #1;
      end
      iv16 = 1'b0; or16 = 1'b1;
      check("bp_count", got16.size(), 5);
      for (int i = 0; i < 5; i++)
         check("bp_order", (i < got16.size()) ? 64'(got16[i]) : 64'hDEAD_BEEF, 64'(2 * (i + 1)));

      // Reset mid-flight
      iv16 = 1'b1; a16 = 16'h0003; b16 = 16'h0003; ci16 = 1'b0; sub16 = 1'b0;
      @(posedge cp2); #1;
      a16 = 16'h0007; b16 = 16'h0007;
      @(posedge cp2); #1;
      iv16 = 1'b0;
      check("pre_reset_valid", ov16, 1'b1);
      #2 ireset = 1'b0;
      #1;
      check("async_reset_clear", {ov16, s16, co16, z16, n16, v16, h16, ir16}, '0);
      @(posedge cp2);
      #2 ireset = 1'b1;
      @(posedge cp2); #1;
      check("ready_after_reset", ir16, 1'b1);
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (ov16) seen++;
         @(posedge cp2); #1;
      end
      check("no_stale_beat", seen, 0);

      // 32-bit / 4-stage: unstalled latency
      for (int j = 0; j < 4; j++) begin
         iv32 = 1'b1; a32 = $urandom; b32 = $urandom;
         ci32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
         e = model(32, a32, b32, ci32, sub32);
         @(posedge cp2); #1;
         iv32 = 1'b0;
         lat = 1;
         while (!ov32 && lat < 20) begin
            @(posedge cp2); #1;
            lat++;
         end
         check("lat32", lat, 4);
         check("lat32_result", {s32, co32, z32, n32, v32, h32},
               {e.s[31:0], e.co, e.z, e.n, e.v, e.h});
         @(posedge cp2); #1;
      end

      // 32-bit / 4-stage: random beats with random backpressure
      acc = 0; cyc = 0;
      while ((acc < NBEATS || expq.size() != 0) && cyc < 60000) begin
         iv32  = (acc < NBEATS) && ($urandom_range(0, 9) < 8);
         a32   = $urandom;
         b32   = $urandom;
         ci32  = 1'($urandom_range(0, 1));
         sub32 = 1'($urandom_range(0, 1));
         or32  = ($urandom_range(0, 9) < 7);
         #1;
         check("rand_in_ready", ir32, !ov32 || or32);
         if (ov32 && or32) begin
            if (expq.size() == 0) begin
               check("rand_unexpected_beat", ov32, 1'b0);
            end else begin
               e = expq.pop_front();
               check("rand_result", {s32, co32, z32, n32, v32, h32},
                     {e.s[31:0], e.co, e.z, e.n, e.v, e.h});
            end
         end
         if (iv32 && ir32) begin
            expq.push_back(model(32, a32, b32, ci32, sub32));
            acc++;
         end
         @(posedge cp2); #1;
         cyc++;
      end
      iv32 = 1'b0; or32 = 1'b1;
      check("rand_beats_accepted", acc, NBEATS);
      check("rand_queue_drained", expq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
